// File: rtl/lane_serializer_8n.sv
// Bundle-to-stream sequencer: buffers up to eight N-bit lane words and emits them
// lane 0 first through an 8:1 word mux steered by a lane counter.

module mux_8NtoN #(
  parameter int N = 24
) (
  input  logic [8*N-1:0] d,
  input  logic [2:0]     s,
  input  logic           en,
  output logic [N-1:0]   y
);

  always_comb begin
    y = '0;
    if (en) y = d[s*N +: N];
  end

endmodule

module lane_serializer_8n #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*N-1:0] in_words,
  input  logic [3:0]     in_len,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic [2:0]     out_idx,
  output logic           out_last,
  output logic           busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. Once out_valid is raised, out_data/out_idx/out_last hold until it is taken.
  // in_ready may depend on out_ready so a new bundle can load on the final beat.

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     sel_q, sel_d;
  logic [3:0]     len_q, len_d;
  logic [8*N-1:0] buf_q;
  logic           load;
  logic           accept;
  logic           xfer;
  logic           last;
  logic [3:0]     len_clamped;
  logic [N-1:0]   mux_y;

  assign len_clamped = (in_len > 4'd8) ? 4'd8 : in_len;

  // busy doubles as the visible state indicator for the FSM.
  assign busy      = (state_q == SEND);
  assign out_valid = busy;
  assign last      = busy && ({1'b0, sel_q} == (len_q - 4'd1));
  assign in_ready  = rst && ((state_q == IDLE) || (busy && out_ready && last));
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  mux_8NtoN #(.N(N)) u_mux (
    .d  (buf_q),
    .s  (sel_q),
    .en (busy),
    .y  (mux_y)
  );

  assign out_data = busy ? mux_y : '0;
  assign out_idx  = busy ? sel_q : 3'd0;
  assign out_last = last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      len_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
    end else if (load) begin
      buf_q <= in_words;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      SEND: begin
        if (xfer) begin
          if (!last) begin
            sel_d = sel_q + 3'd1;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A zero-length bundle is consumed without producing any beat.
    if (load) begin
      len_d   = len_clamped;
      sel_d   = 3'd0;
      state_d = (len_clamped != 4'd0) ? SEND : IDLE;
    end
  end

endmodule

// File: tb/tb_lane_serializer_8n.sv
// Self-checking bench for lane_serializer_8n: accepted bundles are expanded into
// expected beats on a queue and compared against every output transfer.

module tb_lane_serializer_8n;

  localparam int N  = 24;
  localparam int BW = 3 + 1 + N;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [8*N-1:0] in_words;
  logic [3:0]     in_len;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  logic [2:0]     out_idx;
  logic           out_last;
  logic           busy;

  logic [BW-1:0] exp_q[$];
  int            n_checks;
  int            n_fail;
  int            idle_gaps;

  lane_serializer_8n #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_words  (in_words),
    .in_len    (in_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: pop on each output transfer, then push beats of any bundle accepted
  // on the same edge
  always @(negedge clk) begin
    if (rst) begin
      if (!out_valid) idle_gaps++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {out_idx, out_last, out_data}, '0);
        end else begin
          check("beat", {out_idx, out_last, out_data}, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        int n;
        n = (in_len > 4'd8) ? 8 : int'(in_len);
        for (int k = 0; k < n; k++) begin
          logic [2:0] kidx;
          kidx = k[2:0];
          exp_q.push_back({kidx, (k == n - 1), in_words[k*N +: N]});
        end
      end
    end
  end

  // driver tasks
  task automatic send_bundle(input logic [8*N-1:0] words, input logic [3:0] len);
    int budget;
    @(posedge clk); #1;
    in_words = words;
    in_len   = len;
    in_valid = 1'b1;
    budget   = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!in_ready && budget < 200);
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  function automatic logic [8*N-1:0] rand_words();
    logic [8*N-1:0] w;
    for (int k = 0; k < 8; k++) w[k*N +: N] = $urandom_range(0, (1 << N) - 1);
    return w;
  endfunction

  function automatic logic [8*N-1:0] ramp_words();
    logic [8*N-1:0] w;
    for (int k = 0; k < 8; k++) w[k*N +: N] = k * 24'h111111;
    return w;
  endfunction

  initial begin
    logic [8*N-1:0] w;
    n_checks  = 0;
    n_fail    = 0;
    idle_gaps = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_words  = '0;
    in_len    = 4'd0;
    out_ready = 1'b0;

    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      in_len    = $urandom_range(0, 15);
      in_words  = rand_words();
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_data", out_data, 0);
      check("rst_meta", {out_idx, out_last, busy}, 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    // 2: full ramp bundle
    send_bundle(ramp_words(), 4'd8);
    check("lat_lane0_valid", out_valid, 1);
    check("lat_lane0_idx", out_idx, 0);
    wait_drain();

    // 3: short, clamped and zero lengths
    send_bundle(rand_words(), 4'd3);
    wait_drain();
    send_bundle(rand_words(), 4'd12);
    wait_drain();
    send_bundle(rand_words(), 4'd1);
    wait_drain();
    @(posedge clk); #1;
    send_bundle(rand_words(), 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_len_valid", out_valid, 0);
      check("zero_len_ready", in_ready, 1);
    end

    // 4: back-pressure on lane 1
    w = rand_words();
    send_bundle(w, 4'd4);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_idx", out_idx, 1);
      check("stall_data", out_data, w[N +: N]);
      check("stall_in_ready", in_ready, 0);
      in_words = rand_words();
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // 5: back-to-back bundles with no idle cycle between them
    send_bundle(ramp_words(), 4'd8);
    idle_gaps = 0;
    send_bundle(rand_words(), 4'd5);
    wait_drain();
    check("b2b_gaps", idle_gaps, 0);

    // random traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #2;
          out_ready = $urandom_range(0, 3) != 0;
        end
      end
      begin
        for (int i = 0; i < 4; i++) send_bundle(rand_words(), 4'($urandom_range(0, 15)));
      end
    join
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();

    // 6: reset in the middle of a bundle
    send_bundle(ramp_words(), 4'd8);
    begin
      int budget;
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (out_idx != 3'd3 && budget < 50);
      check("mid_rst_reach_idx3", out_idx, 3);
    end
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("after_rst_valid", out_valid, 0);
      check("after_rst_busy", busy, 0);
    end
    check("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
